// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM between fetch (port 0) and load/store (port 1).
// Grants are combinational; read responses are registered one cycle after acceptance.
module ram_arbiter #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req0_valid,
  input  logic                 req0_we,
  input  logic [ADDR_BITS-1:0] req0_addr,
  input  logic [DATA_BITS-1:0] req0_wdata,
  input  logic                 req0_lock,
  output logic                 req0_ready,
  output logic                 rsp0_valid,
  output logic [DATA_BITS-1:0] rsp0_rdata,
  input  logic                 req1_valid,
  input  logic                 req1_we,
  input  logic [ADDR_BITS-1:0] req1_addr,
  input  logic [DATA_BITS-1:0] req1_wdata,
  input  logic                 req1_lock,
  output logic                 req1_ready,
  output logic                 rsp1_valid,
  output logic [DATA_BITS-1:0] rsp1_rdata,
  output logic                 mem_rd_en,
  output logic [ADDR_BITS-1:0] mem_rd_addr,
  input  logic [DATA_BITS-1:0] mem_rd_data,
  output logic                 mem_wr_en,
  output logic [ADDR_BITS-1:0] mem_wr_addr,
  output logic [DATA_BITS-1:0] mem_wr_data
);

  logic                 last_grant;
  logic                 locked;
  logic                 lock_owner;
  logic                 any_grant;
  logic                 sel;
  logic                 g_we;
  logic                 g_lock;
  logic [ADDR_BITS-1:0] g_addr;
  logic [DATA_BITS-1:0] g_wdata;

  // A held lock excludes the other port even while the owner is idle.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (locked) begin
      if (lock_owner) req1_ready = req1_valid;
      else            req0_ready = req0_valid;
    end else if (req0_valid && req1_valid) begin
      if (last_grant) req0_ready = 1'b1;
      else            req1_ready = 1'b1;
    end else begin
      req0_ready = req0_valid;
      req1_ready = req1_valid;
    end
  end

  assign any_grant = req0_ready | req1_ready;
  assign sel       = req1_ready;
  assign g_we      = sel ? req1_we    : req0_we;
  assign g_lock    = sel ? req1_lock  : req0_lock;
  assign g_addr    = sel ? req1_addr  : req0_addr;
  assign g_wdata   = sel ? req1_wdata : req0_wdata;

  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (any_grant) begin
      if (g_we) begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = g_addr;
        mem_wr_data = g_wdata;
      end else begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = g_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      locked     <= 1'b0;
      lock_owner <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= req0_ready && !req0_we;
      rsp1_valid <= req1_ready && !req1_we;
      if (req0_ready && !req0_we) rsp0_rdata <= mem_rd_data;
      if (req1_ready && !req1_we) rsp1_rdata <= mem_rd_data;
      if (any_grant) begin
        last_grant <= sel;
        // Only the owner can be granted while locked, so an unlocked transfer releases it.
        if (g_lock) begin
          locked     <= 1'b1;
          lock_owner <= sel;
        end else if (locked) begin
          locked <= 1'b0;
        end
      end
    end
  end

endmodule
